// File: rtl/mips_multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: FSM states,
// opcode/funct values, ALU operation codes and the coarse ALU-op selector.
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;
endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Unified-memory request/ready handshake between the controller and memory.
interface mips_multicycle_controller_if;
    logic mem_req;
    logic memwrite;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output memwrite, output iord, input mem_ready);
    modport slave  (input mem_req, input memwrite, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_controller_aludec.sv
// ALU decoder: maps the coarse ALU op (and funct for R-type) to an ALU code.
// funct_ok reflects funct alone so DECODE can reject bad R-types early.
module mc_aludec
    import mc_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  aluop_t            aluop,
    input  logic [5:0]        funct,
    output logic [ALUC_W-1:0] alucontrol,
    output logic              funct_ok
);
    logic [3:0] fn_code;
    logic [3:0] code;

    always_comb begin
        funct_ok = 1'b1;
        fn_code  = ALU_ADD;
        case (funct)
            FN_ADD:  fn_code = ALU_ADD;
            FN_SUB:  fn_code = ALU_SUB;
            FN_AND:  fn_code = ALU_AND;
            FN_OR:   fn_code = ALU_OR;
            FN_SLT:  fn_code = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
        case (aluop)
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_FUNCT: code = fn_code;
            default:     code = ALU_ADD;
        endcase
        alucontrol = ALUC_W'(code);
    end
endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore FSM sequencing the shared multicycle MIPS datapath.
// Define MC_BNE_EN to decode bne (op 000101) through the branch state.
module mips_multicycle_controller
    import mc_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               op,
    input  logic [5:0]               funct,
    input  logic                     zero,
    mips_multicycle_controller_if.master mem,
    output logic                     irwrite,
    output logic                     regdst,
    output logic                     memtoreg,
    output logic                     regwrite,
    output logic                     alusrca,
    output logic [1:0]               alusrcb,
    output logic [1:0]               pcsrc,
    output logic                     pcen,
    output logic [ALUC_W-1:0]        alucontrol,
    output logic                     illegal_op
);
`ifdef MC_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    state_t state, state_n;
    aluop_t aluop;
    logic   funct_ok;
    logic   mem_req, memwrite, iord;
    logic   ne;

    mc_aludec #(.ALUC_W(ALUC_W)) u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol),
        .funct_ok   (funct_ok)
    );

    assign mem.mem_req  = mem_req;
    assign mem.memwrite = memwrite;
    assign mem.iord     = iord;
    // IR is stable after FETCH, so op still identifies bne while in BEQEX.
    assign ne = BNE_EN && (op == OP_BNE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = S_FETCH;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem.mem_ready;
                pcen    = mem.mem_ready;
                state_n = mem.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE: begin
                        state_n    = funct_ok ? S_RTYPEEX : S_FETCH;
                        illegal_op = ~funct_ok;
                    end
                    OP_BEQ:  state_n = S_BEQEX;
                    OP_BNE: begin
                        state_n    = BNE_EN ? S_BEQEX : S_FETCH;
                        illegal_op = ~BNE_EN;
                    end
                    OP_ADDI: state_n = S_ADDIEX;
                    OP_J:    state_n = S_JEX;
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_n = mem.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                state_n  = mem.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_n = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                pcen    = zero ^ ne;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_n = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: state_n = S_FETCH;
        endcase
        // Reset wins over any in-flight access: nothing is strobed this cycle.
        if (reset) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            iord       = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            pcsrc      = 2'b00;
            pcen       = 1'b0;
            aluop      = ALUOP_ADD;
            illegal_op = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench: each scenario queues the expected control word per cycle
// and compares it against the DUT outputs sampled on the falling edge.
module tb_mips_multicycle_controller;
    typedef struct packed {
        logic       mem_req, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       pcen;
        logic [3:0] alucontrol;
        logic       illegal_op;
    } ctrl_t;

    logic clk = 1'b0;
    logic reset, zero;
    logic [5:0] op, funct;
    logic irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;
    int n_chk = 0, n_fail = 0;
    ctrl_t exp_q[$];

    always #5 clk = ~clk;

    mips_multicycle_controller_if mif ();

    mips_multicycle_controller #(.ALUC_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem(mif.master),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
        .alucontrol(alucontrol), .illegal_op(illegal_op)
    );

    function automatic ctrl_t sample();
        ctrl_t c;
        c = '{mif.mem_req, mif.memwrite, mif.iord, irwrite, regdst, memtoreg, regwrite,
              alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op};
        return c;
    endfunction

    // Expected control words, written straight from the state descriptions.
    function automatic ctrl_t e_base();
        ctrl_t c = '0; c.alucontrol = 4'b0010; return c;
    endfunction
    function automatic ctrl_t e_fetch(logic r);
        ctrl_t c = e_base(); c.mem_req = 1; c.alusrcb = 2'b01; c.irwrite = r; c.pcen = r; return c;
    endfunction
    function automatic ctrl_t e_decode(logic ill);
        ctrl_t c = e_base(); c.alusrcb = 2'b11; c.illegal_op = ill; return c;
    endfunction
    function automatic ctrl_t e_memadr();
        ctrl_t c = e_base(); c.alusrca = 1; c.alusrcb = 2'b10; return c;
    endfunction
    function automatic ctrl_t e_memrd();
        ctrl_t c = e_base(); c.mem_req = 1; c.iord = 1; return c;
    endfunction
    function automatic ctrl_t e_memwb();
        ctrl_t c = e_base(); c.regwrite = 1; c.memtoreg = 1; return c;
    endfunction
    function automatic ctrl_t e_memwr();
        ctrl_t c = e_base(); c.mem_req = 1; c.memwrite = 1; c.iord = 1; return c;
    endfunction
    function automatic ctrl_t e_rex(logic [3:0] a);
        ctrl_t c = e_base(); c.alusrca = 1; c.alucontrol = a; return c;
    endfunction
    function automatic ctrl_t e_rwb();
        ctrl_t c = e_base(); c.regwrite = 1; c.regdst = 1; return c;
    endfunction
    function automatic ctrl_t e_beq(logic p);
        ctrl_t c = e_base(); c.alusrca = 1; c.alucontrol = 4'b0110; c.pcsrc = 2'b01; c.pcen = p; return c;
    endfunction
    function automatic ctrl_t e_addiwb();
        ctrl_t c = e_base(); c.regwrite = 1; return c;
    endfunction
    function automatic ctrl_t e_jex();
        ctrl_t c = e_base(); c.pcsrc = 2'b10; c.pcen = 1; return c;
    endfunction

    task automatic test_reset();
        ctrl_t obs, e;
        reset = 1; mif.mem_ready = 1; op = 6'b100011; funct = 0; zero = 0;
        @(posedge clk); #1;
        exp_q.push_back(e_base());
        @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
        @(posedge clk); #1; reset = 0; mif.mem_ready = 0;
        exp_q.push_back(e_fetch(0));
        @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_fetch got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_lw_stall();
        ctrl_t obs, e;
        ctrl_t ex[$] = '{e_fetch(0), e_fetch(0), e_fetch(0), e_fetch(1), e_decode(0), e_memadr(),
                         e_memrd(), e_memrd(), e_memrd(), e_memwb()};
        logic  rd[$] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
        op = 6'b100011;
        for (int i = 0; i < ex.size(); i++) begin
            mif.mem_ready = rd[i]; exp_q.push_back(ex[i]);
            @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL lw[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        ctrl_t obs, e;
        logic [5:0] fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [3:0] ac[5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        op = 6'b000000; mif.mem_ready = 1;
        for (int k = 0; k < 5; k++) begin
            ctrl_t ex[$] = '{e_fetch(1), e_decode(0), e_rex(ac[k]), e_rwb()};
            funct = fn[k];
            for (int i = 0; i < ex.size(); i++) begin
                exp_q.push_back(ex[i]);
                @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
                if (obs !== e) begin n_fail++; $display("FAIL rtype%0d[%0d] got=%h exp=%h", k, i, obs, e); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        ctrl_t obs, e;
        ctrl_t ex[$];
        logic  zr[$];
        op = 6'b000100; funct = 6'b111111; mif.mem_ready = 1;
        ex = '{e_fetch(1), e_decode(0), e_beq(1), e_fetch(1), e_decode(0), e_beq(0)};
        zr = '{0, 0, 1, 1, 1, 0};
        for (int i = 0; i < ex.size(); i++) begin
            zero = zr[i]; exp_q.push_back(ex[i]);
            @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL beq[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne();
        ctrl_t obs, e;
`ifdef MC_BNE_EN
        ctrl_t ex[$] = '{e_fetch(1), e_decode(0), e_beq(1), e_fetch(1)};
`else
        ctrl_t ex[$] = '{e_fetch(1), e_decode(1), e_fetch(1), e_decode(0)};
`endif
        op = 6'b000101; zero = 0; mif.mem_ready = 1;
        for (int i = 0; i < ex.size(); i++) begin
`ifndef MC_BNE_EN
            if (i == 3) op = 6'b000010;
`endif
            exp_q.push_back(ex[i]);
            @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL bne[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
`ifndef MC_BNE_EN
        exp_q.push_back(e_jex());
        @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL jex got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_addi_j();
        ctrl_t obs, e;
        ctrl_t ex[$] = '{e_fetch(1), e_decode(0), e_memadr(), e_addiwb(),
                         e_fetch(1), e_decode(0), e_jex(), e_fetch(0)};
        mif.mem_ready = 1;
        for (int i = 0; i < ex.size(); i++) begin
            op = (i < 4) ? 6'b001000 : 6'b000010;
            if (i == 7) mif.mem_ready = 0;
            exp_q.push_back(ex[i]);
            @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL addi_j[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_reset();
        ctrl_t obs, e;
        ctrl_t ex[$] = '{e_fetch(1), e_decode(0), e_memadr(), e_memwr(), e_base(), e_fetch(0), e_fetch(0)};
        logic  rd[$] = '{1, 0, 0, 0, 0, 0, 0};
        logic  rs[$] = '{0, 0, 0, 0, 1, 0, 0};
        op = 6'b101011;
        for (int i = 0; i < ex.size(); i++) begin
            mif.mem_ready = rd[i]; reset = rs[i]; exp_q.push_back(ex[i]);
            @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL sw_reset[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        ctrl_t obs, e;
        ctrl_t ex[$] = '{e_fetch(1), e_decode(1), e_fetch(1), e_decode(1), e_fetch(0), e_fetch(0)};
        int    ill_cnt = 0;
        mif.mem_ready = 1;
        for (int i = 0; i < ex.size(); i++) begin
            op = (i < 2) ? 6'b111111 : 6'b000000;
            funct = 6'b000111;
            if (i >= 4) mif.mem_ready = 0;
            exp_q.push_back(ex[i]);
            @(negedge clk); obs = sample(); e = exp_q.pop_front(); n_chk++;
            if (obs.illegal_op) ill_cnt++;
            if (obs !== e) begin n_fail++; $display("FAIL illegal[%0d] got=%h exp=%h", i, obs, e); end
            @(posedge clk); #1;
        end
        n_chk++;
        if (ill_cnt !== 2) begin n_fail++; $display("FAIL illegal_pulses got=%0d exp=2", ill_cnt); end
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_rtype();
        test_branch();
        test_bne();
        test_addi_j();
        test_sw_reset();
        test_illegal();
        n_chk++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
